// File: rtl/fat32_write_sequencer.sv
// fat32_write_sequencer
// Mounts a FAT32 card (MBR then BPR read), derives the partition layout, then
// streams whole data sectors into one contiguous file. A FAT sector is
// refreshed whenever a new cluster opens. On flush, the final FAT sector and
// the root-directory sector are written.
// Optional build macro: SECTOR_TIMEOUT_EN adds a per-request watchdog.
module fat32_write_sequencer #(
  parameter int unsigned ClusterShift  = 5,
  parameter logic [31:0] TimeoutCycles = 32'd2_000_000
) (
  input  logic        Clock,
  input  logic        sys_rst,
  input  logic        start,
  output logic        sectorRequest,
  output logic        sectorWrite,
  output logic [31:0] sectorAddress,
  input  logic        sectorDone,
  input  logic        sectorError,
  output logic        mbrEdit,
  output logic        bprEdit,
  input  logic [31:0] theBPRDirectory,
  input  logic [31:0] theRootDirectory,
  input  logic [15:0] ReservedSectors,
  input  logic [7:0]  SectorsPerCluster,
  input  logic [31:0] RootClusterNumber,
  input  logic        dataSectorReady,
  output logic        dataSectorTaken,
  input  logic        flush,
  output logic [1:0]  dataSource,
  output logic [31:0] fileSectorLength,
  output logic [31:0] fileStartSector,
  output logic        mounted,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, RD_MBR, RD_BPR, CALC0, CALC1, WAIT_DATA,
    WR_DATA, WR_FAT, WR_DIR, DONE, ERROR
  } state_t;

  localparam logic [31:0] ClusterBase = 32'(ClusterShift);

  state_t      state_q, state_d;
  logic        req_q, taken_q, mounted_q;
  logic        fat_pend_q, flush_q, final_q, fat_second_q;
  logic [31:0] file_len_q, file_start_q, fat_start_q, data_start_q, offs_q;
  logic [31:0] cluster_count_q;
  logic [7:0]  clu_sec_q, spc_q;

  logic        in_xfer, active, xfer_done, fail, timeout, go_final, fat_split;
  logic [31:0] entry, fat_idx;

  assign in_xfer   = state_q inside {RD_MBR, RD_BPR, WR_DATA, WR_FAT, WR_DIR};
  assign active    = !(state_q inside {IDLE, DONE, ERROR});
  assign xfer_done = req_q && sectorDone;
  assign fail      = active && (sectorError || timeout);

  // FAT entry of the newest cluster. When it is the first entry of a FAT
  // sector, the previous sector holding the chain link is written first.
  assign entry     = ClusterBase + cluster_count_q;
  assign fat_split = (entry[6:0] == 7'd0) && (cluster_count_q != 32'd0);
  assign fat_idx   = (fat_split && !fat_second_q) ? entry - 32'd1 : entry;

  // Flush is serviced only once data and pending FAT work are drained.
  assign go_final  = (state_q == WAIT_DATA) && !dataSectorReady && !fat_pend_q && flush_q;

`ifdef SECTOR_TIMEOUT_EN
  logic [31:0] wd_cnt_q;

  // Watchdog: count cycles spent with a request outstanding.
  always_ff @(posedge Clock) begin
    if (sys_rst || !req_q) wd_cnt_q <= '0;
    else                   wd_cnt_q <= wd_cnt_q + 32'd1;
  end

  assign timeout = req_q && (wd_cnt_q == TimeoutCycles - 32'd1);
`else
  // The timeout length only matters when the watchdog is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and the per-state transfer setup driven to the SD engine.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_d       = state_q;
    sectorWrite   = 1'b0;
    sectorAddress = '0;
    dataSource    = 2'd0;
    mbrEdit       = 1'b0;
    bprEdit       = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = RD_MBR;
      RD_MBR: begin
        mbrEdit = 1'b1;
        if (xfer_done) state_d = RD_BPR;
      end
      RD_BPR: begin
        bprEdit       = 1'b1;
        sectorAddress = theBPRDirectory;
        if (xfer_done) state_d = CALC0;
      end
      CALC0:  state_d = CALC1;
      CALC1:  state_d = WAIT_DATA;
      WAIT_DATA: begin
        if (dataSectorReady)          state_d = (file_len_q == '1) ? ERROR : WR_DATA;
        else if (fat_pend_q || flush_q) state_d = WR_FAT;
      end
      WR_DATA: begin
        sectorWrite   = 1'b1;
        sectorAddress = file_start_q + file_len_q;
        if (xfer_done) state_d = WAIT_DATA;
      end
      WR_FAT: begin
        sectorWrite   = 1'b1;
        dataSource    = 2'd1;
        sectorAddress = fat_start_q + (fat_idx >> 7);
        if (xfer_done) begin
          if (fat_split && !fat_second_q) state_d = WR_FAT;
          else if (final_q)               state_d = WR_DIR;
          else                            state_d = WAIT_DATA;
        end
      end
      WR_DIR: begin
        sectorWrite   = 1'b1;
        dataSource    = 2'd2;
        sectorAddress = data_start_q;
        if (xfer_done) state_d = DONE;
      end
      default: state_d = state_q;
    endcase
    if (fail) state_d = ERROR;
  end

  // Request handshake, layout registers and file/cluster bookkeeping.
  always_ff @(posedge Clock) begin
    if (sys_rst) begin
      req_q           <= 1'b0;
      taken_q         <= 1'b0;
      mounted_q       <= 1'b0;
      fat_pend_q      <= 1'b0;
      flush_q         <= 1'b0;
      final_q         <= 1'b0;
      fat_second_q    <= 1'b0;
      file_len_q      <= '0;
      file_start_q    <= '0;
      fat_start_q     <= '0;
      data_start_q    <= '0;
      offs_q          <= '0;
      cluster_count_q <= '0;
      clu_sec_q       <= '0;
      spc_q           <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      taken_q <= 1'b0;

      // Request rises one cycle into a transfer state and drops on completion.
      if (fail || xfer_done) req_q <= 1'b0;
      else if (in_xfer)      req_q <= 1'b1;

      if ((state_q inside {WAIT_DATA, WR_DATA, WR_FAT}) && flush) flush_q <= 1'b1;
      if (go_final) final_q <= 1'b1;

      if (!fail) begin
        case (state_q)
          CALC0: begin
            fat_start_q  <= theBPRDirectory + {16'd0, ReservedSectors};
            data_start_q <= theBPRDirectory + theRootDirectory;
            offs_q       <= (ClusterBase - RootClusterNumber) * {24'd0, SectorsPerCluster};
            spc_q        <= SectorsPerCluster;
          end
          CALC1: begin
            file_start_q <= data_start_q + offs_q;
            mounted_q    <= 1'b1;
          end
          WR_DATA: if (xfer_done) begin
            taken_q    <= 1'b1;
            file_len_q <= file_len_q + 32'd1;
            if (clu_sec_q == spc_q - 8'd1) begin
              clu_sec_q       <= '0;
              cluster_count_q <= cluster_count_q + 32'd1;
              fat_pend_q      <= 1'b1;
            end else begin
              clu_sec_q <= clu_sec_q + 8'd1;
            end
          end
          WR_FAT: if (xfer_done) begin
            fat_second_q <= fat_split && !fat_second_q;
            fat_pend_q   <= 1'b0;
          end
          default: ;
        endcase
      end

      if (state_d == ERROR) mounted_q <= 1'b0;
    end
  end

  assign sectorRequest    = req_q;
  assign dataSectorTaken  = taken_q;
  assign fileSectorLength = file_len_q;
  assign fileStartSector  = file_start_q;
  assign mounted          = mounted_q;
  assign done             = (state_q == DONE);
  assign error            = (state_q == ERROR);

endmodule

// File: tb/tb_fat32_write_sequencer.sv
// tb_fat32_write_sequencer
// Table of card layouts, each mounted, streamed and flushed, with an SD-engine
// responder that pops expected transfers from a scoreboard queue. Hand-written
// sequences cover error abort, reset mid-transfer and (with SECTOR_TIMEOUT_EN)
// the watchdog.
module tb_fat32_write_sequencer;

  logic        Clock = 1'b0;
  logic        sys_rst, start, sectorDone, sectorError, dataSectorReady, flush;
  logic [31:0] theBPRDirectory, theRootDirectory, RootClusterNumber;
  logic [15:0] ReservedSectors;
  logic [7:0]  SectorsPerCluster;
  logic        sectorRequest, sectorWrite, mbrEdit, bprEdit, dataSectorTaken;
  logic        mounted, done, error;
  logic [31:0] sectorAddress, fileSectorLength, fileStartSector;
  logic [1:0]  dataSource;

  always #5 Clock = ~Clock;

  fat32_write_sequencer #(.ClusterShift(5), .TimeoutCycles(32'd100)) dut (
    .Clock(Clock), .sys_rst(sys_rst), .start(start),
    .sectorRequest(sectorRequest), .sectorWrite(sectorWrite),
    .sectorAddress(sectorAddress), .sectorDone(sectorDone),
    .sectorError(sectorError), .mbrEdit(mbrEdit), .bprEdit(bprEdit),
    .theBPRDirectory(theBPRDirectory), .theRootDirectory(theRootDirectory),
    .ReservedSectors(ReservedSectors), .SectorsPerCluster(SectorsPerCluster),
    .RootClusterNumber(RootClusterNumber), .dataSectorReady(dataSectorReady),
    .dataSectorTaken(dataSectorTaken), .flush(flush), .dataSource(dataSource),
    .fileSectorLength(fileSectorLength), .fileStartSector(fileStartSector),
    .mounted(mounted), .done(done), .error(error)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  src;
    logic        mbr;
    logic        bpr;
    logic [31:0] addr;
  } xfer_t;

  typedef struct {
    logic [31:0] part;
    logic [15:0] res;
    logic [31:0] root;
    logic [7:0]  spc;
    logic [31:0] root_clus;
    int          nsec;
    bit          flush_with_data;
    logic [31:0] exp_file_start;
    logic [31:0] exp_fat_start;
    logic [31:0] exp_dir;
  } vec_t;

  xfer_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic push(input logic wr, input logic [1:0] src, input logic mbr,
                      input logic bpr, input logic [31:0] addr);
    xfer_t x;
    x.wr = wr; x.src = src; x.mbr = mbr; x.bpr = bpr; x.addr = addr;
    exp_q.push_back(x);
  endtask

  // FAT write(s) expected for the cluster count current at the write.
  task automatic push_fat(input logic [31:0] fat_start, input int cc);
    logic [31:0] ent;
    ent = 32'd5 + 32'(cc);
    if (ent[6:0] == 7'd0 && cc != 0) push(1'b1, 2'd1, 1'b0, 1'b0, fat_start + ((ent - 32'd1) >> 7));
    push(1'b1, 2'd1, 1'b0, 1'b0, fat_start + (ent >> 7));
  endtask

  // SD engine model: wait for a request, score it, hold it, then end it.
  task automatic serve_one(input int lat, input bit err);
    int    n;
    bit    stable;
    xfer_t e, got;
    n = 0;
    while (sectorRequest !== 1'b1 && n < 300) begin tick(); n++; end
    if (sectorRequest !== 1'b1) begin
      check("request_seen", {63'd0, sectorRequest}, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    got = {sectorWrite, dataSource, mbrEdit, bprEdit, sectorAddress};
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_request: got %0h required none", got);
    end else begin
      e = exp_q.pop_front();
      check("xfer_addr", {32'd0, got.addr}, {32'd0, e.addr});
      check("xfer_ctl", {59'd0, got.wr, got.src, got.mbr, got.bpr},
                        {59'd0, e.wr, e.src, e.mbr, e.bpr});
    end
    stable = 1'b1;
    repeat (lat) begin
      tick();
      if ({sectorWrite, dataSource, mbrEdit, bprEdit, sectorAddress} !== got ||
          sectorRequest !== 1'b1) stable = 1'b0;
    end
    check("xfer_stable", {63'd0, stable}, 64'd1);
    if (err) sectorError = 1'b1;
    else     sectorDone  = 1'b1;
    tick();
    sectorDone  = 1'b0;
    sectorError = 1'b0;
    check("req_drop", {63'd0, sectorRequest}, 64'd0);
    // Upstream releases its sector once the sequencer reports it taken.
    if (dataSectorTaken) dataSectorReady = 1'b0;
  endtask

  task automatic quiet_check(input string name);
    bit quiet;
    quiet = 1'b1;
    repeat (8) begin
      tick();
      if (sectorRequest !== 1'b0) quiet = 1'b0;
    end
    check(name, {63'd0, quiet}, 64'd1);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    start = 1'b0; sectorDone = 1'b0; sectorError = 1'b0;
    dataSectorReady = 1'b0; flush = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    sys_rst = 1'b0;
  endtask

  task automatic mount(input vec_t v);
    theBPRDirectory   = v.part;
    ReservedSectors   = v.res;
    theRootDirectory  = v.root;
    SectorsPerCluster = v.spc;
    RootClusterNumber = v.root_clus;
    push(1'b0, 2'd0, 1'b1, 1'b0, 32'd0);
    push(1'b0, 2'd0, 1'b0, 1'b1, v.part);
    start = 1'b1;
    tick();
    start = 1'b0;
    serve_one($urandom_range(0, 3), 1'b0);
    serve_one($urandom_range(0, 3), 1'b0);
    check("mount_lat0", {63'd0, mounted}, 64'd0);
    tick();
    check("mount_lat1", {63'd0, mounted}, 64'd0);
    tick();
    check("mount_lat2", {63'd0, mounted}, 64'd1);
    check("file_start", {32'd0, fileStartSector}, {32'd0, v.exp_file_start});
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h2000, 16'h20, 32'h7A2, 8'd8, 32'd2, 9, 1'b0, 32'h27BA, 32'h2020, 32'h27A2};
    vecs[1] = '{32'h2000, 16'h20, 32'h7A2, 8'd8, 32'd2, 3, 1'b0, 32'h27BA, 32'h2020, 32'h27A2};
    vecs[2] = '{32'h2000, 16'h20, 32'h7A2, 8'd8, 32'd2, 3, 1'b1, 32'h27BA, 32'h2020, 32'h27A2};
    vecs[3] = '{32'h800, 16'h24, 32'h3000, 8'd1, 32'd2, 3, 1'b0, 32'h3803, 32'h824, 32'h3800};
    vecs[4] = '{32'h100, 16'h10, 32'h200, 8'd4, 32'd7, 5, 1'b0, 32'h2F8, 32'h110, 32'h300};
    vecs[5] = '{32'h4000, 16'h20, 32'h100, 8'd2, 32'd5, 0, 1'b0, 32'h4100, 32'h4020, 32'h4100};
    vecs[6] = '{32'h10000, 16'h40, 32'h1000, 8'd1, 32'd2, 123, 1'b0, 32'h11003, 32'h10040, 32'h11000};

    for (int k = 0; k < 7; k++) begin
      do_reset();
      check("rst_outputs", {26'd0, sectorRequest, sectorWrite, mbrEdit, bprEdit,
                            dataSectorTaken, dataSource, mounted, done, error},
                           64'd0);
      check("rst_addr_len", {sectorAddress, fileSectorLength}, 64'd0);
      check("rst_start", {32'd0, fileStartSector}, 64'd0);
      mount(vecs[k]);

      for (int i = 0; i < vecs[k].nsec; i++) begin
        bit last;
        last = (i == vecs[k].nsec - 1);
        push(1'b1, 2'd0, 1'b0, 1'b0, vecs[k].exp_file_start + 32'(i));
        if ((i + 1) % int'(vecs[k].spc) == 0)
          push_fat(vecs[k].exp_fat_start, (i + 1) / int'(vecs[k].spc));
        if (last && vecs[k].flush_with_data) begin
          push_fat(vecs[k].exp_fat_start, vecs[k].nsec / int'(vecs[k].spc));
          push(1'b1, 2'd2, 1'b0, 1'b0, vecs[k].exp_dir);
          flush = 1'b1;
        end
        dataSectorReady = 1'b1;
        tick();
        flush = 1'b0;
        serve_one($urandom_range(0, 2), 1'b0);
        check("taken_pulse", {63'd0, dataSectorTaken}, 64'd1);
        check("len_step", {32'd0, fileSectorLength}, 64'(i + 1));
        while (exp_q.size() > 0) serve_one($urandom_range(0, 2), 1'b0);
      end

      if (!vecs[k].flush_with_data) begin
        quiet_check("no_extra_req");
        check("len_final", {32'd0, fileSectorLength}, 64'(vecs[k].nsec));
        push_fat(vecs[k].exp_fat_start, vecs[k].nsec / int'(vecs[k].spc));
        push(1'b1, 2'd2, 1'b0, 1'b0, vecs[k].exp_dir);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        while (exp_q.size() > 0) serve_one($urandom_range(0, 2), 1'b0);
      end

      check("done_set", {62'd0, done, error}, 64'd2);
      start = 1'b1;
      tick();
      start = 1'b0;
      quiet_check("done_quiet");
      check("done_hold", {63'd0, done}, 64'd1);
    end

    // Stray sectorDone with no request, then sectorError during WR_DATA.
    do_reset();
    mount(vecs[0]);
    sectorDone = 1'b1;
    tick();
    sectorDone = 1'b0;
    check("stray_done_len", {32'd0, fileSectorLength}, 64'd0);
    check("stray_done_taken", {63'd0, dataSectorTaken}, 64'd0);
    push(1'b1, 2'd0, 1'b0, 1'b0, 32'h27BA);
    dataSectorReady = 1'b1;
    tick();
    serve_one(1, 1'b1);
    dataSectorReady = 1'b0;
    check("err_set", {61'd0, error, mounted, done}, 64'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    quiet_check("err_quiet");
    check("err_hold", {63'd0, error}, 64'd1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("err_cleared", {63'd0, error}, 64'd0);

    // Reset while a data write request is outstanding.
    do_reset();
    mount(vecs[0]);
    dataSectorReady = 1'b1;
    repeat (3) tick();
    check("req_before_rst", {63'd0, sectorRequest}, 64'd1);
    sys_rst = 1'b1;
    tick();
    check("req_after_rst", {63'd0, sectorRequest}, 64'd0);
    sys_rst = 1'b0;
    dataSectorReady = 1'b0;

`ifdef SECTOR_TIMEOUT_EN
    // Watchdog: request held for exactly TimeoutCycles, then error.
    begin
      int n;
      do_reset();
      mount(vecs[0]);
      dataSectorReady = 1'b1;
      n = 0;
      while (sectorRequest !== 1'b1 && n < 20) begin tick(); n++; end
      n = 0;
      while (sectorRequest === 1'b1 && n < 300) begin tick(); n++; end
      dataSectorReady = 1'b0;
      check("timeout_cycles", 64'(n), 64'd100);
      check("timeout_error", {63'd0, error}, 64'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
